venera_periph_timer: RTL and testbench

- Peripheral-port responder on the CPU's peripheral bus. Serves CPU write strobes and read strobes (read completion is signalled with a done pulse).
- Hosts an 8-register map: programmable prescaled down-counter timer, GPIO output/input, status and ID.
- Sits beside the CPU in the top level: CPU port outputs feed its inputs, its o_p_dout/o_p_rd_done feed the CPU's i_p_din/i_p_rd_done.

---
 rtl/venera_periph_timer.sv | 150 +++++++++++++++
 tb/tb_venera_periph_timer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/venera_periph_timer.sv
// Peripheral-bus responder: prescaled down-counter timer, GPIO, status, ID.
// Reads complete RD_LATENCY cycles after the strobe with a one-cycle done pulse.
module venera_periph_timer #(
  parameter logic [7:0] BASE_ADDR  = 8'h10,
  parameter int         RD_LATENCY = 1
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_p_wr_strobe,
  input  logic       i_p_rd_strobe,
  input  logic [7:0] i_p_addr,
  input  logic [7:0] i_p_din,
  output logic [7:0] o_p_dout,
  output logic       o_p_rd_done,
  input  logic [7:0] i_gpio,
  output logic [7:0] o_gpio,
  output logic       o_irq
);

  localparam logic [7:0] ID_VAL = 8'hA5;
  localparam int         LAST   = RD_LATENCY - 1;

  logic [2:0] ctrl;
  logic [7:0] reload;
  logic [7:0] count;
  logic       expired;
  logic [7:0] gpio_out;
  logic [7:0] gpio_s1;
  logic [7:0] gpio_s2;
  logic [7:0] prescale;
  logic [7:0] ps;

  logic       hit;
  logic [2:0] off;
  logic       wr_ctrl;
  logic       wr_reload;
  logic       wr_count;
  logic       wr_status;
  logic       wr_gpio;
  logic       wr_pre;
  logic       tick;
  logic       expire_set;
  logic [7:0] rdata;
  logic       rd_pending;
  logic       rd_acc;

  logic [LAST:0] pv;
  logic [7:0]    pd [RD_LATENCY];
  logic [7:0]    dout_q;

  assign hit = i_p_addr[7:3] == BASE_ADDR[7:3];
  assign off = i_p_addr[2:0];

  assign wr_ctrl   = i_p_wr_strobe && hit && off == 3'd0;
  assign wr_reload = i_p_wr_strobe && hit && off == 3'd1;
  assign wr_count  = i_p_wr_strobe && hit && off == 3'd2;
  assign wr_status = i_p_wr_strobe && hit && off == 3'd3;
  assign wr_gpio   = i_p_wr_strobe && hit && off == 3'd4;
  assign wr_pre    = i_p_wr_strobe && hit && off == 3'd6;

  assign tick       = ctrl[0] && ps == prescale;
  assign expire_set = tick && count == 8'd1 && !wr_count;

  always_comb begin
    rdata = 8'h00;
    unique case (off)
      3'd0: rdata = {5'b0, ctrl};
      3'd1: rdata = reload;
      3'd2: rdata = count;
      3'd3: rdata = {7'b0, expired};
      3'd4: rdata = gpio_out;
      3'd5: rdata = gpio_s2;
      3'd6: rdata = prescale;
      3'd7: rdata = ID_VAL;
    endcase
  end

  // The done cycle still counts as pending, so back-to-back strobes are dropped.
  assign rd_pending = |pv;
  assign rd_acc     = i_p_rd_strobe && hit && !rd_pending;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      ctrl     <= '0;
      reload   <= '0;
      prescale <= '0;
      gpio_out <= '0;
      gpio_s1  <= '0;
      gpio_s2  <= '0;
    end else begin
      gpio_s1 <= i_gpio;
      gpio_s2 <= gpio_s1;
      if (wr_ctrl)   ctrl     <= i_p_din[2:0];
      if (wr_reload) reload   <= i_p_din;
      if (wr_pre)    prescale <= i_p_din;
      if (wr_gpio)   gpio_out <= i_p_din;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      ps      <= '0;
      count   <= '0;
      expired <= 1'b0;
    end else begin
      if (wr_count)
        ps <= '0;
      else if (ctrl[0])
        ps <= tick ? 8'd0 : ps + 8'd1;

      if (wr_count)
        count <= i_p_din;
      else if (tick) begin
        if (count > 8'd1)
          count <= count - 8'd1;
        else if (count == 8'd1)
          count <= ctrl[1] ? reload : 8'd0;
      end

      if (expire_set)
        expired <= 1'b1;
      else if (wr_status && i_p_din[0])
        expired <= 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      pv     <= '0;
      dout_q <= '0;
      for (int i = 0; i < RD_LATENCY; i++)
        pd[i] <= '0;
    end else begin
      pv[0] <= rd_acc;
      pd[0] <= rdata;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pv[i] <= pv[i-1];
        pd[i] <= pd[i-1];
      end
      if (pv[LAST])
        dout_q <= pd[LAST];
    end
  end

  assign o_p_rd_done = pv[LAST];
  assign o_p_dout    = pv[LAST] ? pd[LAST] : dout_q;
  assign o_gpio      = gpio_out;
  assign o_irq       = expired && ctrl[2];

endmodule

// File: tb/tb_venera_periph_timer.sv
// Directed bench for venera_periph_timer: two instances, read latency 1 and 3.
// Expected values are hand-computed from the register map and timer timing.
module tb_venera_periph_timer;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_s;
  logic       rd_s;
  logic [7:0] addr;
  logic [7:0] din;
  logic [7:0] gpio_in;

  logic [7:0] dout1, dout3;
  logic       done1, done3;
  logic [7:0] gpio1, gpio3;
  logic       irq1, irq3;

  int n_cmp = 0;
  int n_err = 0;
  int nd1 = 0;
  int nd3 = 0;

  always #5 clk = ~clk;

  venera_periph_timer #(.BASE_ADDR(8'h10), .RD_LATENCY(1)) u_dut1 (
    .i_clk(clk), .i_reset(rst),
    .i_p_wr_strobe(wr_s), .i_p_rd_strobe(rd_s),
    .i_p_addr(addr), .i_p_din(din),
    .o_p_dout(dout1), .o_p_rd_done(done1),
    .i_gpio(gpio_in), .o_gpio(gpio1), .o_irq(irq1)
  );

  venera_periph_timer #(.BASE_ADDR(8'h10), .RD_LATENCY(3)) u_dut3 (
    .i_clk(clk), .i_reset(rst),
    .i_p_wr_strobe(wr_s), .i_p_rd_strobe(rd_s),
    .i_p_addr(addr), .i_p_din(din),
    .o_p_dout(dout3), .o_p_rd_done(done3),
    .i_gpio(gpio_in), .o_gpio(gpio3), .o_irq(irq3)
  );

  always @(posedge clk) begin
    if (done1) nd1++;
    if (done3) nd3++;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    addr = a;
    din  = d;
    wr_s = 1'b1;
    @(negedge clk);
    wr_s = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a,
                    output logic [7:0] d1, output int l1,
                    output logic [7:0] d3, output int l3);
    @(negedge clk);
    addr = a;
    rd_s = 1'b1;
    d1 = '0; d3 = '0; l1 = 0; l3 = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 1) rd_s = 1'b0;
      if (done1 && l1 == 0) begin l1 = i; d1 = dout1; end
      if (done3 && l3 == 0) begin l3 = i; d3 = dout3; end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d1, d3;
    int l1, l3, c1, c3;
    logic [7:0] ar_exp [5];
    ar_exp[0] = 8'd1; ar_exp[1] = 8'd2; ar_exp[2] = 8'd3;
    ar_exp[3] = 8'd1; ar_exp[4] = 8'd2;

    rst = 1'b1; wr_s = 0; rd_s = 0; addr = 0; din = 0; gpio_in = 0;
    repeat (3) @(negedge clk);
    check("rst_done", done1, 0);
    check("rst_dout", dout1, 0);
    check("rst_gpio", gpio1, 0);
    check("rst_irq", irq1, 0);
    check("rst_done3", done3, 0);
    rst = 1'b0;

    c1 = nd1; c3 = nd3;
    rd(8'h17, d1, l1, d3, l3);
    check("id_data1", d1, 8'hA5);
    check("id_lat1", l1, 1);
    check("id_data3", d3, 8'hA5);
    check("id_lat3", l3, 3);
    check("id_hold", dout1, 8'hA5);
    check("id_pulses1", nd1 - c1, 1);
    check("id_pulses3", nd3 - c3, 1);

    wr(8'h16, 8'd3);
    wr(8'h12, 8'd2);
    wr(8'h10, 8'h05);
    check("irq_early", irq1, 0);
    repeat (7) @(negedge clk);
    check("irq_c8", irq1, 0);
    @(negedge clk);
    check("irq_rise", irq1, 1);
    check("irq_rise3", irq3, 1);
    rd(8'h12, d1, l1, d3, l3);
    check("count_zero", d1, 0);
    repeat (10) @(negedge clk);
    rd(8'h12, d1, l1, d3, l3);
    check("count_stay", d1, 0);
    rd(8'h13, d1, l1, d3, l3);
    check("status_set", d1, 8'h01);
    check("irq_held", irq1, 1);
    wr(8'h13, 8'h01);
    check("irq_clr", irq1, 0);

    wr(8'h10, 8'h00);
    wr(8'h16, 8'd0);
    wr(8'h11, 8'd3);
    wr(8'h12, 8'd1);
    wr(8'h10, 8'h03);
    for (int i = 0; i < 5; i++) begin
      addr = 8'h12;
      rd_s = 1'b1;
      @(negedge clk);
      rd_s = 1'b0;
      check("ar_done", done1, 1);
      check($sformatf("ar_count%0d", i), dout1, ar_exp[i]);
      @(negedge clk);
    end
    check("ar_noirq", irq1, 0);
    rd(8'h13, d1, l1, d3, l3);
    check("ar_status", d1, 8'h01);
    wr(8'h10, 8'h00);

    wr(8'h14, 8'h5A);
    check("gpio_out", gpio1, 8'h5A);
    @(negedge clk);
    gpio_in = 8'hC3;
    repeat (2) @(negedge clk);
    rd(8'h15, d1, l1, d3, l3);
    check("gpio_in", d1, 8'hC3);

    c1 = nd1;
    @(negedge clk);
    addr = 8'h20; rd_s = 1'b1;
    @(negedge clk);
    rd_s = 1'b0;
    repeat (4) @(negedge clk);
    check("miss_rd", nd1 - c1, 0);

    c1 = nd1; c3 = nd3;
    addr = 8'h15; rd_s = 1'b1;
    @(negedge clk);
    addr = 8'h17;
    @(negedge clk);
    rd_s = 1'b0;
    repeat (4) @(negedge clk);
    check("pend_one1", nd1 - c1, 1);
    check("pend_one3", nd3 - c3, 1);
    check("pend_data", dout1, 8'hC3);
    wr(8'h24, 8'hFF);
    check("wr_miss", gpio1, 8'h5A);

    gpio_in = 8'h00;
    repeat (3) @(negedge clk);
    c3 = nd3;
    addr = 8'h11; rd_s = 1'b1;
    @(negedge clk);
    rd_s = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_cancel", nd3 - c3, 0);
    check("rst2_gpio", gpio1, 0);
    check("rst2_irq", irq1, 0);
    check("rst2_dout1", dout1, 0);
    check("rst2_dout3", dout3, 0);
    for (int i = 0; i < 8; i++) begin
      rd(8'h10 + 8'(i), d1, l1, d3, l3);
      check($sformatf("rst2_reg%0d", i), d1, (i == 7) ? 8'hA5 : 8'h00);
    end
    check("rst2_lat3", l3, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
